// File: rtl/onewire_byte.sv
// rtl/onewire_byte.sv - 1-wire byte sequencer driving a bit-cycle master; optional CRC-8 under ONEWIRE_BYTE_CRC_EN
module onewire_byte #(
  parameter bit OVD_DEF = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_ovd,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_presence,
  output logic [7:0]  rsp_crc,
  output logic        owm_write,
  output logic        owm_read,
  output logic [31:0] owm_writedata,
  input  logic [31:0] owm_readdata,
  input  logic        owm_waitrequest
);

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    POLL  = 3'd2,
    NEXT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        ovd_q, ovd_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic        bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_pres_q, rsp_pres_d;

`ifdef ONEWIRE_BYTE_CRC_EN
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  rsp_crc_q, rsp_crc_d;
  logic        crc_bit;
  logic        crc_fb;
`endif

  logic        dtx;
  logic        rst_bit;
  logic        last_bit;
  logic        bit_done;

  // Only the transmit-done and received-bit status flags matter to this block.
  logic        unused_readdata;
  assign unused_readdata = ^{owm_readdata[31:5], owm_readdata[2:0]};

  // Reset slots drive the reset bit; read slots transmit a 1 so the slave can pull low.
  assign rst_bit  = (op_q == OP_RST);
  assign dtx      = (op_q == OP_WR) ? data_q[idx_q] : (op_q == OP_RD);
  assign last_bit = (op_q == OP_RST) || (idx_q == 3'd7);
  assign bit_done = !owm_waitrequest && owm_readdata[4];

  // State and datapath registers, cleared asynchronously so an abort leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_RST;
      ovd_q      <= 1'b0;
      data_q     <= 8'd0;
      idx_q      <= 3'd0;
      bit_q      <= 1'b0;
      shreg_q    <= 8'd0;
      rsp_data_q <= 8'd0;
      rsp_pres_q <= 1'b0;
`ifdef ONEWIRE_BYTE_CRC_EN
      crc_q      <= 8'd0;
      rsp_crc_q  <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ovd_q      <= ovd_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      rsp_data_q <= rsp_data_d;
      rsp_pres_q <= rsp_pres_d;
`ifdef ONEWIRE_BYTE_CRC_EN
      crc_q      <= crc_d;
      rsp_crc_q  <= rsp_crc_d;
`endif
    end
  end

  // Next-state: one bit-cycle is issued, polled to completion, then retired.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = (cmd_op == OP_CLR) ? RESP : ISSUE;
      ISSUE:   if (!owm_waitrequest) state_d = POLL;
      POLL:    if (bit_done) state_d = NEXT;
      NEXT:    state_d = last_bit ? RESP : ISSUE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the command, capture each bit, assemble the response on the way into RESP.
  always_comb begin
    op_d       = op_q;
    ovd_d      = ovd_q;
    data_d     = data_q;
    idx_d      = idx_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    rsp_data_d = rsp_data_q;
    rsp_pres_d = rsp_pres_q;
`ifdef ONEWIRE_BYTE_CRC_EN
    crc_d      = crc_q;
    rsp_crc_d  = rsp_crc_q;
    crc_bit    = (op_q == OP_WR) ? data_q[idx_q] : bit_q;
    crc_fb     = crc_q[0] ^ crc_bit;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          ovd_d   = cmd_ovd | OVD_DEF;
          data_d  = cmd_data;
          idx_d   = 3'd0;
          shreg_d = 8'd0;
          if (cmd_op == OP_CLR) begin
            rsp_data_d = 8'd0;
            rsp_pres_d = 1'b0;
`ifdef ONEWIRE_BYTE_CRC_EN
            crc_d      = 8'd0;
            rsp_crc_d  = 8'd0;
`endif
          end
        end
      end
      POLL: begin
        if (bit_done) bit_d = owm_readdata[3];
      end
      NEXT: begin
        if (op_q == OP_RD) shreg_d[idx_q] = bit_q;
`ifdef ONEWIRE_BYTE_CRC_EN
        if (op_q == OP_WR || op_q == OP_RD)
          crc_d = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
`endif
        if (last_bit) begin
          rsp_data_d = (op_q == OP_RD) ? shreg_d : ((op_q == OP_WR) ? data_q : 8'd0);
          rsp_pres_d = (op_q == OP_RST) ? ~bit_q : 1'b0;
`ifdef ONEWIRE_BYTE_CRC_EN
          rsp_crc_d  = crc_d;
`endif
        end else begin
          idx_d = 3'(idx_q + 3'd1);
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state only, so read and write strobes are mutually exclusive.
  always_comb begin
    cmd_ready     = (state_q == IDLE);
    owm_write     = (state_q == ISSUE);
    owm_read      = (state_q == POLL);
    rsp_valid     = (state_q == RESP);
    owm_writedata = 32'd0;
    if (state_q == ISSUE)
      owm_writedata = {24'd0, 2'b00, 3'b000, dtx, rst_bit, ovd_q};
  end

  assign rsp_data     = rsp_data_q;
  assign rsp_presence = rsp_pres_q;
`ifdef ONEWIRE_BYTE_CRC_EN
  assign rsp_crc      = rsp_crc_q;
`else
  assign rsp_crc      = 8'd0;
`endif

endmodule

// File: tb/tb_onewire_byte.sv
// tb/tb_onewire_byte.sv - randomized bench for onewire_byte with a bit-master/slave model and scoreboard
module tb_onewire_byte;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_ovd;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_presence;
  logic [7:0]  rsp_crc;
  logic        owm_write;
  logic        owm_read;
  logic [31:0] owm_writedata;
  logic [31:0] owm_readdata;
  logic        owm_waitrequest;

  onewire_byte dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_ovd         (cmd_ovd),
    .cmd_data        (cmd_data),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_presence    (rsp_presence),
    .rsp_crc         (rsp_crc),
    .owm_write       (owm_write),
    .owm_read        (owm_read),
    .owm_writedata   (owm_writedata),
    .owm_readdata    (owm_readdata),
    .owm_waitrequest (owm_waitrequest)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboard / model state
  logic [31:0] exp_words[$];
  logic [7:0]  exp_data;
  logic        exp_pres;
  logic [7:0]  exp_crc;
  logic [7:0]  model_crc = 8'd0;
  logic [7:0]  last_data = 8'd0;
  logic        last_pres = 1'b0;
  logic [7:0]  last_crc  = 8'd0;
  logic [7:0]  got_data, got_crc;
  logic        got_pres;
  int          rsp_count = 0;
  int          wr_count  = 0;
  logic [31:0] last_wd   = 32'd0;
  logic [7:0]  dtx_hist  = 8'd0;

  // bit-master / slave model state
  logic        slave_present = 1'b0;
  logic [7:0]  slave_sh = 8'hFF;
  int          bm_cnt = 0;
  logic        bm_done = 1'b0;
  logic        bm_rx = 1'b0;
  int          stall_w = 0;
  int          stall_r = 0;
  logic        prev_w_stall = 1'b0;
  logic        prev_r_stall = 1'b0;
  logic [31:0] prev_wd = 32'd0;
  logic        prev_rsp_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = (r >> 1) ^ (fb ? 8'h8C : 8'h00);
    end
    return r;
  endfunction

  // Bit master + slave model and per-cycle compare, all on the falling edge.
  initial begin
    logic wr;
    owm_waitrequest = 1'b0;
    owm_readdata    = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bm_cnt = 0; bm_done = 1'b0; owm_waitrequest = 1'b0; owm_readdata = 32'd0;
        prev_w_stall = 1'b0; prev_r_stall = 1'b0; prev_rsp_valid = 1'b0;
        last_data = 8'd0; last_pres = 1'b0; last_crc = 8'd0;
        continue;
      end
      if (prev_w_stall) check("write_held", {owm_write, owm_writedata}, {1'b1, prev_wd});
      if (prev_r_stall) check("read_held", owm_read, 1);
      check("rd_wr_exclusive", owm_read & owm_write, 0);
      if (bm_cnt > 0) begin
        bm_cnt--;
        if (bm_cnt == 0) bm_done = 1'b1;
      end
      wr = ($urandom_range(0, 3) == 0);
      if (owm_write && stall_w > 0) begin wr = 1'b1; stall_w--; end
      if (owm_read && stall_r > 0) begin wr = 1'b1; stall_r--; end
      owm_waitrequest = wr;
      owm_readdata    = $urandom;
      owm_readdata[4] = bm_done;
      owm_readdata[3] = bm_done ? bm_rx : 1'($urandom_range(0, 1));
      prev_w_stall = owm_write && wr;
      prev_r_stall = owm_read && wr;
      prev_wd      = owm_writedata;
      if (owm_write && !wr) begin
        wr_count++;
        last_wd  = owm_writedata;
        dtx_hist = {owm_writedata[2], dtx_hist[7:1]};
        check("write_expected", exp_words.size() > 0, 1);
        if (exp_words.size() > 0) check("writedata", owm_writedata, exp_words.pop_front());
        bm_done = 1'b0;
        bm_cnt  = $urandom_range(1, 5);
        if (owm_writedata[1]) bm_rx = ~slave_present;
        else begin
          bm_rx    = owm_writedata[2] & slave_sh[0];
          slave_sh = {1'b1, slave_sh[7:1]};
        end
      end
      if (rsp_valid) begin
        check("rsp_one_cycle", prev_rsp_valid, 0);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_presence", rsp_presence, exp_pres);
        check("rsp_crc", rsp_crc, exp_crc);
        check("all_bits_issued", exp_words.size(), 0);
        got_data = rsp_data; got_pres = rsp_presence; got_crc = rsp_crc;
        last_data = exp_data; last_pres = exp_pres; last_crc = exp_crc;
        rsp_count++;
      end else begin
        check("rsp_hold", {rsp_data, rsp_presence, rsp_crc}, {last_data, last_pres, last_crc});
      end
      prev_rsp_valid = rsp_valid;
    end
  end

  task automatic start_cmd(input logic [1:0] op, input logic [7:0] d, input logic ovd,
                           input logic present, input logic [7:0] sb, input logic stall);
    int n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("ready_before_cmd", cmd_ready, 1);
    case (op)
      2'b00: begin
        exp_words.push_back({29'd0, 1'b0, 1'b1, ovd});
        exp_data = 8'd0; exp_pres = present;
      end
      2'b01: begin
        for (int i = 0; i < 8; i++) exp_words.push_back({29'd0, d[i], 1'b0, ovd});
        exp_data = d; exp_pres = 1'b0; model_crc = crc8(model_crc, d);
      end
      2'b10: begin
        for (int i = 0; i < 8; i++) exp_words.push_back({29'd0, 1'b1, 1'b0, ovd});
        exp_data = sb; exp_pres = 1'b0; model_crc = crc8(model_crc, sb);
      end
      default: begin
        exp_data = 8'd0; exp_pres = 1'b0; model_crc = 8'd0;
      end
    endcase
`ifdef ONEWIRE_BYTE_CRC_EN
    exp_crc = model_crc;
`else
    exp_crc = 8'd0;
`endif
    slave_present = present;
    slave_sh = (op == 2'b10) ? sb : 8'hFF;
    stall_w  = stall ? 5 : 0;
    stall_r  = stall ? 5 : 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_ovd = ovd;
    @(negedge clk);
  endtask

  task automatic finish_cmd();
    int n = 0;
    while (!rsp_valid && n < 3000) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cmd_data  = 8'($urandom);
      cmd_ovd   = 1'($urandom);
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    check("rsp_timeout", n < 3000, 1);
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input logic ovd,
                        input logic present, input logic [7:0] sb, input logic stall);
    start_cmd(op, d, ovd, present, sb, stall);
    finish_cmd();
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] rom [8];
    rom[0] = 8'h02; rom[1] = 8'h1C; rom[2] = 8'hB8; rom[3] = 8'h01;
    rom[4] = 8'h00; rom[5] = 8'h00; rom[6] = 8'h00; rom[7] = 8'hA2;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ovd = 1'b0; cmd_data = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_crc, owm_write, owm_read, owm_writedata},
          {1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0});
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);

    // bus reset with and without a slave
    base = wr_count;
    do_cmd(2'b00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);
    check("rst_op_writes", wr_count - base, 1);
    check("rst_op_word", last_wd, 32'h0000_0002);
    check("rst_op_presence", got_pres, 1);
    do_cmd(2'b00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);
    check("rst_op_no_slave", got_pres, 0);

    // write 0xA5, read 0x3C
    base = wr_count;
    do_cmd(2'b01, 8'hA5, 1'b0, 1'b0, 8'hFF, 1'b0);
    check("wr_a5_writes", wr_count - base, 8);
    check("wr_a5_dtx_seq", dtx_hist, 8'hA5);
    check("wr_a5_rsp", got_data, 8'hA5);
    base = wr_count;
    do_cmd(2'b10, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0);
    check("rd_3c_writes", wr_count - base, 8);
    check("rd_3c_word", last_wd, 32'h0000_0004);
    check("rd_3c_rsp", got_data, 8'h3C);

    // stalls on first write and first read
    base = wr_count;
    do_cmd(2'b01, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b1);
    check("stall_wr_writes", wr_count - base, 8);
    check("stall_wr_consumed", stall_w + stall_r, 0);
    check("stall_wr_rsp", got_data, 8'h5A);
    do_cmd(2'b10, 8'h00, 1'b1, 1'b0, 8'h96, 1'b1);
    check("stall_rd_rsp", got_data, 8'h96);

    // CRC over a ROM code
    do_cmd(2'b11, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_cmd(2'b10, 8'h00, 1'b0, 1'b0, rom[i], 1'b0);
`ifdef ONEWIRE_BYTE_CRC_EN
      if (i == 6) check("crc_after_7", got_crc, 8'hA2);
      if (i == 7) check("crc_after_8", got_crc, 8'h00);
`else
      check("crc_tied_zero", got_crc, 8'h00);
`endif
    end

    // reset in the middle of bit 3 of a write
    base = wr_count;
    n = rsp_count;
    start_cmd(2'b01, 8'hC3, 1'b0, 1'b0, 8'hFF, 1'b0);
    cmd_valid = 1'b0;
    for (int k = 0; k < 500 && (wr_count - base) < 4; k++) @(negedge clk);
    check("abort_reached_bit3", wr_count - base, 4);
    rst = 1'b1;
    #1;
    check("abort_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_crc, owm_write, owm_read, owm_writedata},
          {1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0});
    exp_words.delete();
    model_crc = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_rsp", rsp_count, n);
    do_cmd(2'b01, 8'h3E, 1'b0, 1'b0, 8'hFF, 1'b0);
    check("after_abort_rsp", got_data, 8'h3E);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      do_cmd(2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
             $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
